dmem_arbiter: RTL and testbench

- Shares the single-port data memory (wr, rd, 9-bit addr, DATA_W data, 1-cycle read latency) between the core datapath (port C) and a debug/loader master (port D).
- Round-robin grant on contention, a stall signal back to the core, and a halt handshake. The halt handshake lets the debug master take exclusive memory ownership after in-flight core traffic drains.
- Sits between Datapath memory-stage signals and the data memory instance.

---
 rtl/dmem_arbiter_if.sv | 59 +++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/debug requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view. The master modport is the view of
// whoever drives requests and memory read data.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    // Core port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // Debug / loader port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Halt handshake
    logic              halt_req;
    logic              halt_ack;

    // Single-port data memory
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  halt_req,
        output halt_ack,
        output mem_wr, mem_rd, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output halt_req,
        input  halt_ack,
        input  mem_wr, mem_rd, mem_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the core datapath
// and a debug/loader master. Round-robin on contention. The halt handshake
// gives the debug master exclusive ownership once core reads have retired.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_e            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              pend_rd_q, pend_rd_d;
    logic              pend_owner_q, pend_owner_d;

    logic              c_gnt;
    logic              d_gnt;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              c_rvalid;
    logic              d_rvalid;

    // Grant decision from registered state; reset forces every grant low at once
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (bus.c_req && (!bus.d_req || rr_last_q == OWN_D)) begin
                        c_gnt = 1'b1;
                    end else if (bus.d_req) begin
                        d_gnt = 1'b1;
                    end
                end
                default: begin
                    // Draining or halted: the core is locked out
                    d_gnt = bus.d_req;
                end
            endcase
        end
    end

    // Memory command mux: the granted port drives the memory, otherwise all zero
    always_comb begin
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        if (c_gnt) begin
            mem_wr    = bus.c_we;
            mem_rd    = ~bus.c_we;
            addr_mux  = bus.c_addr;
            wdata_mux = bus.c_wdata;
        end else if (d_gnt) begin
            mem_wr    = bus.d_we;
            mem_rd    = ~bus.d_we;
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
        end
    end

    // Next-state logic: round-robin pointer, read-return tracking and halt FSM
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        pend_rd_d    = 1'b0;
        pend_owner_d = pend_owner_q;

        if (c_gnt) begin
            rr_last_d = OWN_C;
            if (!bus.c_we) begin
                pend_rd_d    = 1'b1;
                pend_owner_d = OWN_C;
            end
        end else if (d_gnt) begin
            rr_last_d = OWN_D;
            if (!bus.d_we) begin
                pend_rd_d    = 1'b1;
                pend_owner_d = OWN_D;
            end
        end

        case (state_q)
            RUN: begin
                if (bus.halt_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A read already in flight returns this cycle. So the memory is
                // free of core traffic once no core read is issued now.
                if (!bus.halt_req) begin
                    state_d = RUN;
                end else if (!pend_rd_d || pend_owner_d == OWN_D) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!bus.halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State registers; reset drops any pending read return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            rr_last_q    <= OWN_D;
            pend_rd_q    <= 1'b0;
            pend_owner_q <= OWN_C;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            pend_rd_q    <= pend_rd_d;
            pend_owner_q <= pend_owner_d;
        end
    end

    assign c_rvalid = pend_rd_q && (pend_owner_q == OWN_C);
    assign d_rvalid = pend_rd_q && (pend_owner_q == OWN_D);

    assign bus.c_gnt       = c_gnt;
    assign bus.d_gnt       = d_gnt;
    assign bus.c_stall     = bus.c_req & ~c_gnt & ~reset;
    assign bus.c_rvalid    = c_rvalid;
    assign bus.d_rvalid    = d_rvalid;
    assign bus.c_rdata     = c_rvalid ? bus.mem_rd_data : '0;
    assign bus.d_rdata     = d_rvalid ? bus.mem_rd_data : '0;
    assign bus.halt_ack    = (state_q == HALTED);
    assign bus.mem_wr      = mem_wr;
    assign bus.mem_rd      = mem_rd;
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_wr_data = wdata_mux;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle memory and a
// read-return scoreboard.
module tb_dmem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    typedef struct {
        logic              v;
        logic              own;   // 0 = core, 1 = debug
        logic [DATA_W-1:0] dat;
    } sb_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sh  [0:(1<<ADDR_W)-1];
    sb_t               sb [$];

    dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: write in grant cycle, read data one cycle later
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wr_data;
        bus.mem_rd_data <= bus.mem_rd ? mem[bus.mem_addr] : '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All outputs must be zero while reset is high; pending returns are dropped
    task automatic rst_chk(input string tag);
        #1;
        cmp({tag, ".c_gnt"},    bus.c_gnt,       0);
        cmp({tag, ".d_gnt"},    bus.d_gnt,       0);
        cmp({tag, ".c_stall"},  bus.c_stall,     0);
        cmp({tag, ".c_rvalid"}, bus.c_rvalid,    0);
        cmp({tag, ".d_rvalid"}, bus.d_rvalid,    0);
        cmp({tag, ".c_rdata"},  bus.c_rdata,     0);
        cmp({tag, ".d_rdata"},  bus.d_rdata,     0);
        cmp({tag, ".halt_ack"}, bus.halt_ack,    0);
        cmp({tag, ".mem_wr"},   bus.mem_wr,      0);
        cmp({tag, ".mem_rd"},   bus.mem_rd,      0);
        cmp({tag, ".mem_addr"}, bus.mem_addr,    0);
        cmp({tag, ".mem_wd"},   bus.mem_wr_data, 0);
        sb.delete();
    endtask

    // One clock cycle with the current inputs: check, record, advance
    task automatic chk(input logic ecg, input logic edg, input logic eack, input string tag);
        sb_t               prev;
        sb_t               cur;
        logic              ewr, erd;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ewd;
        #1;
        prev = '{v: 1'b0, own: 1'b0, dat: '0};
        if (sb.size() > 0) prev = sb.pop_front();
        ewr = 1'b0; erd = 1'b0; ea = '0; ewd = '0;
        if (ecg) begin
            ewr = bus.c_we; erd = ~bus.c_we; ea = bus.c_addr; ewd = bus.c_wdata;
        end else if (edg) begin
            ewr = bus.d_we; erd = ~bus.d_we; ea = bus.d_addr; ewd = bus.d_wdata;
        end
        cmp({tag, ".c_gnt"},    bus.c_gnt,       ecg);
        cmp({tag, ".d_gnt"},    bus.d_gnt,       edg);
        cmp({tag, ".c_stall"},  bus.c_stall,     bus.c_req & ~ecg);
        cmp({tag, ".halt_ack"}, bus.halt_ack,    eack);
        cmp({tag, ".mem_wr"},   bus.mem_wr,      ewr);
        cmp({tag, ".mem_rd"},   bus.mem_rd,      erd);
        cmp({tag, ".mem_addr"}, bus.mem_addr,    ea);
        cmp({tag, ".mem_wd"},   bus.mem_wr_data, ewd);
        cmp({tag, ".c_rvalid"}, bus.c_rvalid,    prev.v & ~prev.own);
        cmp({tag, ".d_rvalid"}, bus.d_rvalid,    prev.v & prev.own);
        cmp({tag, ".c_rdata"},  bus.c_rdata,     (prev.v && !prev.own) ? prev.dat : '0);
        cmp({tag, ".d_rdata"},  bus.d_rdata,     (prev.v &&  prev.own) ? prev.dat : '0);
        cur = '{v: erd, own: edg, dat: sh[ea]};
        if (ewr) sh[ea] = ewd;
        sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic drv_c(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
        bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd;
    endtask

    task automatic drv_d(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = 32'hA500_0000 | i;
            sh[i]  = 32'hA500_0000 | i;
        end
        mem[9'h010] = 32'hDEADBEEF;
        sh[9'h010]  = 32'hDEADBEEF;

        reset = 1'b1;
        bus.halt_req = 1'b0;
        drv_c(0, 0, 0, 0);
        drv_d(0, 0, 0, 0);
        rst_chk("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: lone core read, data one cycle later
        drv_c(1, 0, 9'h010, 0);
        chk(1, 0, 0, "t1_gnt");
        drv_c(0, 0, 0, 0);
        chk(0, 0, 0, "t1_rv");

        // Debug-only read leaves the round-robin pointer on debug
        drv_d(1, 0, 9'h020, 0);
        chk(0, 1, 0, "t2_pre");
        drv_d(0, 0, 0, 0);
        chk(0, 0, 0, "t2_pre_rv");

        // 2: continuous contention alternates C,D,C,D
        drv_c(1, 0, 9'h004, 0);
        drv_d(1, 1, 9'h1FF, 32'h12345678);
        chk(1, 0, 0, "t2_c0");
        chk(0, 1, 0, "t2_d0");
        chk(1, 0, 0, "t2_c1");
        chk(0, 1, 0, "t2_d1");
        drv_c(0, 0, 0, 0);
        drv_d(0, 0, 0, 0);
        chk(0, 0, 0, "t2_idle");
        cmp("t2_memword", mem[9'h1FF], 32'h12345678);

        // 3: core read granted as halt rises; drain then halt
        drv_c(1, 0, 9'h030, 0);
        bus.halt_req = 1'b1;
        chk(1, 0, 0, "t3_n");
        drv_c(1, 0, 9'h040, 0);
        chk(0, 0, 0, "t3_n1");
        drv_d(1, 0, 9'h020, 0);
        chk(0, 1, 1, "t3_n2");
        drv_d(0, 0, 0, 0);
        chk(0, 0, 1, "t3_n3");

        // 4: release halt with core request pending
        bus.halt_req = 1'b0;
        chk(0, 0, 1, "t4_drop");
        chk(1, 0, 0, "t4_run");
        drv_c(0, 0, 0, 0);
        chk(0, 0, 0, "t4_rv");

        // 6: halt pulse aborted in drain; pending read still returns
        drv_c(1, 0, 9'h050, 0);
        bus.halt_req = 1'b1;
        chk(1, 0, 0, "t6_gnt");
        drv_c(0, 0, 0, 0);
        bus.halt_req = 1'b0;
        chk(0, 0, 0, "t6_drain");
        drv_c(1, 0, 9'h060, 0);
        chk(1, 0, 0, "t6_run");
        drv_c(0, 0, 0, 0);
        chk(0, 0, 0, "t6_rv");

        // 5: reset mid-stream with a read pending
        drv_c(1, 0, 9'h070, 0);
        chk(1, 0, 0, "t5_gnt");
        drv_d(1, 0, 9'h020, 0);
        reset = 1'b1;
        rst_chk("t5_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk(1, 0, 0, "t5_first");
        chk(0, 1, 0, "t5_second");
        drv_c(0, 0, 0, 0);
        drv_d(0, 0, 0, 0);
        chk(0, 0, 0, "t5_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
